// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin encodings, the coin_value helper and FSM states.
// The SHORT state only exists when HOPPER_STOCK_EN is defined.
package change_dispenser_pkg;

    typedef enum logic [1:0] {
        C0 = 2'b00,
        C1 = 2'b01,
        C2 = 2'b10,
        C5 = 2'b11
    } coin_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_OFFER  = 3'd2,
`ifdef HOPPER_STOCK_EN
        ST_FIN    = 3'd3,
        ST_SHORT  = 3'd4
`else
        ST_FIN    = 3'd3
`endif
    } disp_state_e;

    function automatic logic [2:0] coin_value(input coin_e code);
        logic [2:0] val;
        case (code)
            C1:      val = 3'd1;
            C2:      val = 3'd2;
            C5:      val = 3'd5;
            default: val = 3'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin hopper handshake: the dispenser offers coin_out with coin_valid, the hopper answers with coin_ready.
interface change_dispenser_if;
    logic [1:0] coin_out;
    logic       coin_valid;
    logic       coin_ready;

    modport master (output coin_out, output coin_valid, input coin_ready);
    modport slave  (input coin_out, input coin_valid, output coin_ready);
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Combinational chooser: largest coin in {5,2,1} that fits the remaining amount and is in stock.
module change_dispenser_coin_select
    import change_dispenser_pkg::*;
#(
    parameter int CHANGE_W = 4
) (
    input  logic [CHANGE_W-1:0] remaining_i,
    input  logic [2:0]          avail_i,
    output coin_e               code_o,
    output logic [CHANGE_W-1:0] value_o,
    output logic                none_avail_o
);

    // Priority pick, largest denomination first; avail_i is {C5, C2, C1}.
    always_comb begin
        code_o       = C0;
        none_avail_o = 1'b1;
        if (avail_i[2] && (remaining_i >= CHANGE_W'(3'd5))) begin
            code_o       = C5;
            none_avail_o = 1'b0;
        end else if (avail_i[1] && (remaining_i >= CHANGE_W'(2'd2))) begin
            code_o       = C2;
            none_avail_o = 1'b0;
        end else if (avail_i[0] && (remaining_i >= CHANGE_W'(1'd1))) begin
            code_o       = C1;
            none_avail_o = 1'b0;
        end else begin
            code_o       = C0;
            none_avail_o = 1'b1;
        end
    end

    assign value_o = CHANGE_W'(coin_value(code_o));

endmodule

// File: rtl/change_dispenser.sv
// Pays out change_in as a largest-first coin sequence over a valid/ready hopper handshake.
// HOPPER_STOCK_EN adds per-denomination stock counters, refill input and short/shortfall reporting.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int CHANGE_W = 4
`ifdef HOPPER_STOCK_EN
    ,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done,
    input  logic [CHANGE_W-1:0] change_in,
    change_dispenser_if.master  coin_if,
    output logic                busy,
    output logic                pay_done,
    output logic                overrun
`ifdef HOPPER_STOCK_EN
    ,
    input  logic                refill,
    output logic                short,
    output logic [CHANGE_W-1:0] shortfall
`endif
);

    disp_state_e         state_q, state_d;
    logic [CHANGE_W-1:0] remaining_q, remaining_d;
    logic [CHANGE_W-1:0] val_q, val_d;
    coin_e               code_q, code_d;
    coin_e               coin_out_q;
    logic                coin_valid_q, busy_q, pay_done_q, overrun_q, overrun_d;
    coin_e               sel_code_s;
    logic [CHANGE_W-1:0] sel_value_s;
    logic                none_avail_s;
    logic [2:0]          avail_s;
    logic                hs_s;

`ifdef HOPPER_STOCK_EN
    logic [STOCK_W-1:0]  stock_q [3];
    logic [STOCK_W-1:0]  stock_d [3];
    logic                short_q;
    logic [CHANGE_W-1:0] shortfall_q;

    assign avail_s = {stock_q[2] != {STOCK_W{1'b0}},
                      stock_q[1] != {STOCK_W{1'b0}},
                      stock_q[0] != {STOCK_W{1'b0}}};
`else
    assign avail_s = 3'b111;
`endif

    assign hs_s = coin_valid_q && coin_if.coin_ready;

    change_dispenser_coin_select #(.CHANGE_W(CHANGE_W)) u_coin_select (
        .remaining_i  (remaining_q),
        .avail_i      (avail_s),
        .code_o       (sel_code_s),
        .value_o      (sel_value_s),
        .none_avail_o (none_avail_s)
    );

    // Next-state, remaining-amount and stock bookkeeping.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        code_d      = code_q;
        val_d       = val_q;
        overrun_d   = done && (state_q != ST_IDLE);
`ifdef HOPPER_STOCK_EN
        stock_d     = stock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    if (change_in != {CHANGE_W{1'b0}}) begin
                        remaining_d = change_in;
                        state_d     = ST_SELECT;
                    end else begin
                        state_d     = ST_FIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
`ifdef HOPPER_STOCK_EN
                if (refill) begin
                    for (int i = 0; i < 3; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
                end else begin
                    stock_d = stock_q;
                end
`endif
            end
            ST_SELECT: begin
                if (none_avail_s) begin
`ifdef HOPPER_STOCK_EN
                    state_d     = ST_SHORT;
`else
                    // Unreachable without stock limits; bail out cleanly.
                    remaining_d = {CHANGE_W{1'b0}};
                    state_d     = ST_FIN;
`endif
                end else begin
                    code_d  = sel_code_s;
                    val_d   = sel_value_s;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (hs_s) begin
                    remaining_d = remaining_q - val_q;
`ifdef HOPPER_STOCK_EN
                    case (code_q)
                        C1:      stock_d[0] = stock_q[0] - STOCK_W'(1'b1);
                        C2:      stock_d[1] = stock_q[1] - STOCK_W'(1'b1);
                        C5:      stock_d[2] = stock_q[2] - STOCK_W'(1'b1);
                        default: stock_d    = stock_q;
                    endcase
`endif
                    if (remaining_d == {CHANGE_W{1'b0}}) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end else begin
                    state_d = ST_OFFER;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
`ifdef HOPPER_STOCK_EN
            ST_SHORT: begin
                if (refill) begin
                    for (int i = 0; i < 3; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_SHORT;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                remaining_d = {CHANGE_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= {CHANGE_W{1'b0}};
            val_q        <= {CHANGE_W{1'b0}};
            code_q       <= C0;
            coin_out_q   <= C0;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            pay_done_q   <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef HOPPER_STOCK_EN
            short_q      <= 1'b0;
            shortfall_q  <= {CHANGE_W{1'b0}};
            for (int i = 0; i < 3; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            val_q        <= val_d;
            code_q       <= code_d;
            coin_out_q   <= (state_d == ST_OFFER) ? code_d : C0;
            coin_valid_q <= (state_d == ST_OFFER);
            busy_q       <= (state_d != ST_IDLE);
            pay_done_q   <= (state_d == ST_FIN);
            overrun_q    <= overrun_d;
`ifdef HOPPER_STOCK_EN
            short_q      <= (state_d == ST_SHORT);
            shortfall_q  <= (state_d == ST_SHORT) ? remaining_d : {CHANGE_W{1'b0}};
            stock_q      <= stock_d;
`endif
        end
    end

    assign coin_if.coin_out   = coin_out_q;
    assign coin_if.coin_valid = coin_valid_q;
    assign busy               = busy_q;
    assign pay_done           = pay_done_q;
    assign overrun            = overrun_q;
`ifdef HOPPER_STOCK_EN
    assign short              = short_q;
    assign shortfall          = shortfall_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; stock scenarios run when HOPPER_STOCK_EN is defined.
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [3:0] change_in;
    logic       busy, pay_done, overrun;
`ifdef HOPPER_STOCK_EN
    logic       refill;
    logic       short;
    logic [3:0] shortfall;
`endif
    int         checks = 0;
    int         errors = 0;
    logic [1:0] coins [$];

    change_dispenser_if coin_if ();

    change_dispenser dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .change_in (change_in),
        .coin_if   (coin_if),
        .busy      (busy),
        .pay_done  (pay_done),
        .overrun   (overrun)
`ifdef HOPPER_STOCK_EN
        ,
        .refill    (refill),
        .short     (short),
        .shortfall (shortfall)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse done for one cycle; returns at cycle T+1.
    task automatic start(input logic [3:0] amt);
        done      = 1'b1;
        change_in = amt;
        tick(1);
        done      = 1'b0;
    endtask

`ifdef HOPPER_STOCK_EN
    task automatic run_pay(input logic [3:0] amt);
        logic got;
        got = 1'b0;
        coins.delete();
        start(amt);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (coin_if.coin_valid && coin_if.coin_ready) coins.push_back(coin_if.coin_out);
            if (pay_done) begin
                got = 1'b1;
                break;
            end
        end
        check("run_pay_done", got, 1);
        tick(1);
    endtask
`endif

    initial begin
        rst = 1'b0; done = 1'b0; change_in = 4'd0; coin_if.coin_ready = 1'b1;
`ifdef HOPPER_STOCK_EN
        refill = 1'b0;
`endif
        tick(2);
        check("rst_valid", coin_if.coin_valid, 0);
        check("rst_coin", coin_if.coin_out, C0);
        check("rst_busy", busy, 0);
        check("rst_paydone", pay_done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b1;
        tick(1);

        // 15 with ready high: C5 x3 at T+2/4/6, pay_done at T+7.
        start(4'd15);
        check("c15_t1_busy", busy, 1);
        check("c15_t1_valid", coin_if.coin_valid, 0);
        tick(1);
        check("c15_t2_valid", coin_if.coin_valid, 1);
        check("c15_t2_coin", coin_if.coin_out, C5);
        tick(1);
        check("c15_t3_valid", coin_if.coin_valid, 0);
        tick(1);
        check("c15_t4_coin", coin_if.coin_out, C5);
        tick(2);
        check("c15_t6_coin", coin_if.coin_out, C5);
        check("c15_t6_paydone", pay_done, 0);
        tick(1);
        check("c15_t7_paydone", pay_done, 1);
        check("c15_t7_valid", coin_if.coin_valid, 0);
        tick(1);
        check("c15_t8_busy", busy, 0);
        check("c15_t8_paydone", pay_done, 0);

        // 8: C5, C2, C1.
        start(4'd8);
        tick(1);
        check("c8_coin0", coin_if.coin_out, C5);
        tick(2);
        check("c8_coin1", coin_if.coin_out, C2);
        tick(2);
        check("c8_coin2", coin_if.coin_out, C1);
        check("c8_valid2", coin_if.coin_valid, 1);
        tick(1);
        check("c8_paydone", pay_done, 1);
        tick(1);

        // 0: no coin, pay_done at T+1.
        start(4'd0);
        check("c0_paydone", pay_done, 1);
        check("c0_valid", coin_if.coin_valid, 0);
        tick(1);
        check("c0_t2_paydone", pay_done, 0);
        check("c0_t2_busy", busy, 0);

        // 3 with ready low three cycles: C2 held stable.
        coin_if.coin_ready = 1'b0;
        start(4'd3);
        tick(1);
        for (int k = 0; k < 4; k++) begin
            check("c3_hold_valid", coin_if.coin_valid, 1);
            check("c3_hold_coin", coin_if.coin_out, C2);
            if (k < 3) tick(1);
        end
        coin_if.coin_ready = 1'b1;
        tick(1);
        check("c3_t6_valid", coin_if.coin_valid, 0);
        tick(1);
        check("c3_t7_coin", coin_if.coin_out, C1);
        tick(1);
        check("c3_t8_paydone", pay_done, 1);
        tick(1);

        // done during payout: overrun once, payout unchanged.
        start(4'd15);
        tick(2);
        done = 1'b1; change_in = 4'd4;
        tick(1);
        done = 1'b0;
        check("ovr_pulse", overrun, 1);
        check("ovr_t4_coin", coin_if.coin_out, C5);
        tick(1);
        check("ovr_clear", overrun, 0);
        tick(1);
        check("ovr_t6_coin", coin_if.coin_out, C5);
        tick(1);
        check("ovr_t7_paydone", pay_done, 1);
        tick(1);
        check("ovr_t8_busy", busy, 0);

        // Reset during OFFER abandons the payout.
        coin_if.coin_ready = 1'b0;
        start(4'd5);
        tick(1);
        check("rsto_valid_before", coin_if.coin_valid, 1);
        rst = 1'b0;
        tick(1);
        check("rsto_valid", coin_if.coin_valid, 0);
        check("rsto_busy", busy, 0);
        rst = 1'b1;
        coin_if.coin_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("rsto_no_paydone", pay_done, 0);
            check("rsto_no_valid", coin_if.coin_valid, 0);
        end

`ifdef HOPPER_STOCK_EN
        // Drain C5 stock (8 coins), then 5 must pay C2, C2, C1.
        run_pay(4'd15);
        run_pay(4'd15);
        run_pay(4'd10);
        run_pay(4'd5);
        check("stk5_count", coins.size(), 3);
        check("stk5_coin0", coins[0], C2);
        check("stk5_coin1", coins[1], C2);
        check("stk5_coin2", coins[2], C1);
        // Drain C2 (6 left) and C1, then 4 goes short.
        run_pay(4'd15);
        run_pay(4'd4);
        start(4'd4);
        tick(1);
        check("short_flag", short, 1);
        check("short_amount", shortfall, 4);
        check("short_valid", coin_if.coin_valid, 0);
        tick(1);
        refill = 1'b1;
        tick(1);
        refill = 1'b0;
        check("short_exit", short, 0);
        check("short_exit_amt", shortfall, 0);
        tick(1);
        check("refill_coin0", coin_if.coin_out, C2);
        tick(3);
        check("refill_paydone", pay_done, 1);
        tick(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
